imm_ext_arbiter: RTL and testbench

Shares one immediate-extension unit between two requesters: port 0 is the decode stage and port 1 is the branch-target unit. Each request carries a 26-bit instruction immediate field and a 3-bit format code. The block arbitrates round-robin, supports locked multi-beat bursts for MOVZ/MOVK wide-constant sequences, and returns the 64-bit extended immediate through a single registered valid/ready output stage.

---
 rtl/imm_ext_pkg.sv | 23 ++
 rtl/imm_ext_core.sv | 30 +++
 rtl/imm_ext_arbiter.sv | 99 +++++++++
 tb/tb_imm_ext_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg
//   Shared definitions for the immediate-extension arbiter slice:
//   - format-code constants selecting how the 26-bit immediate field is
//     extended to 64 bits
//   - arbiter state encoding
package imm_ext_pkg;

   localparam logic [2:0] FMT_I    = 3'b000;  // zero-extend I[21:10]
   localparam logic [2:0] FMT_D    = 3'b001;  // sign-extend I[20:12]
   localparam logic [2:0] FMT_B    = 3'b010;  // sign-extend {I[25:0], 2'b0}
   localparam logic [2:0] FMT_CB   = 3'b011;  // sign-extend {I[23:5], 2'b0}
   localparam logic [2:0] FMT_MOV0 = 3'b100;  // I[20:5] at [15:0]
   localparam logic [2:0] FMT_MOV1 = 3'b101;  // I[20:5] at [31:16]
   localparam logic [2:0] FMT_MOV2 = 3'b110;  // I[20:5] at [47:32]
   localparam logic [2:0] FMT_MOV3 = 3'b111;  // I[20:5] at [63:48]

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_LOCK0 = 2'd1,
      ARB_LOCK1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core
//   Purely combinational immediate extension.
//   Ports:
//     imm  in  26 : instruction bits [25:0]
//     ctrl in   3 : format code (see imm_ext_pkg FMT_*)
//     ext  out 64 : extended immediate
module imm_ext_core
   import imm_ext_pkg::*;
(
   input  logic [25:0] imm,
   input  logic [2:0]  ctrl,
   output logic [63:0] ext
);

   always_comb begin
      ext = '0;
      case (ctrl)
         FMT_I:    ext = {52'b0, imm[21:10]};
         FMT_D:    ext = {{55{imm[20]}}, imm[20:12]};
         FMT_B:    ext = {{36{imm[25]}}, imm[25:0], 2'b00};
         FMT_CB:   ext = {{43{imm[23]}}, imm[23:5], 2'b00};
         FMT_MOV0: ext = {48'b0, imm[20:5]};
         FMT_MOV1: ext = {32'b0, imm[20:5], 16'b0};
         FMT_MOV2: ext = {16'b0, imm[20:5], 32'b0};
         FMT_MOV3: ext = {imm[20:5], 48'b0};
         default:  ext = '0;
      endcase
   end

endmodule

// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter
//   Shares one imm_ext_core between port 0 (decode) and port 1
//   (branch target). Round-robin arbitration with locked bursts, and a
//   single registered valid/ready result stage.
//   Ports:
//     clk, rst            : clock, asynchronous active-high reset
//     req_valid/req_ready : per-port request handshake (2 bits each)
//     req_imm0/1, req_ctrl0/1, req_tag0/1 : per-port request payload
//     req_lock            : per-port "keep grant after this beat"
//     out_valid/out_ready : result handshake
//     out_imm, out_port, out_tag : result payload
module imm_ext_arbiter
   import imm_ext_pkg::*;
#(
   parameter int TAGW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      req_valid,
   output logic [1:0]      req_ready,
   input  logic [25:0]     req_imm0,
   input  logic [25:0]     req_imm1,
   input  logic [2:0]      req_ctrl0,
   input  logic [2:0]      req_ctrl1,
   input  logic [1:0]      req_lock,
   input  logic [TAGW-1:0] req_tag0,
   input  logic [TAGW-1:0] req_tag1,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [63:0]     out_imm,
   output logic            out_port,
   output logic [TAGW-1:0] out_tag
);

   arb_state_t state;
   logic       last_grant;
   logic       slot_free;
   logic [1:0] grant;
   logic       sel;
   logic [25:0] sel_imm;
   logic [2:0]  sel_ctrl;
   logic [63:0] ext;

   // Grant is one-hot or zero; it doubles as req_ready.
   always_comb begin
      slot_free = !out_valid || out_ready;
      grant     = '0;
      if (!rst && slot_free) begin
         case (state)
            ARB_IDLE: begin
               if (req_valid[0] && req_valid[1])
                  grant = last_grant ? 2'b01 : 2'b10;
               else
                  grant = req_valid;
            end
            ARB_LOCK0: grant = {1'b0, req_valid[0]};
            ARB_LOCK1: grant = {req_valid[1], 1'b0};
            default:   grant = '0;
         endcase
      end
   end

   assign req_ready = grant;
   assign sel       = grant[1];
   assign sel_imm   = sel ? req_imm1  : req_imm0;
   assign sel_ctrl  = sel ? req_ctrl1 : req_ctrl0;

   imm_ext_core u_core (
      .imm  (sel_imm),
      .ctrl (sel_ctrl),
      .ext  (ext)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ARB_IDLE;
         last_grant <= 1'b1;
         out_valid  <= 1'b0;
         out_imm    <= '0;
         out_port   <= 1'b0;
         out_tag    <= '0;
      end else if (|grant) begin
         out_valid  <= 1'b1;
         out_imm    <= ext;
         out_port   <= sel;
         out_tag    <= sel ? req_tag1 : req_tag0;
         last_grant <= sel;
         // In a LOCKn state only port n can be granted, so this also
         // covers the lock=0 exit back to IDLE.
         if (req_lock[sel])
            state <= sel ? ARB_LOCK1 : ARB_LOCK0;
         else
            state <= ARB_IDLE;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
module tb_imm_ext_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [25:0] req_imm0, req_imm1;
   logic [2:0]  req_ctrl0, req_ctrl1;
   logic [1:0]  req_lock;
   logic [3:0]  req_tag0, req_tag1;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_imm;
   logic        out_port;
   logic [3:0]  out_tag;

   int total = 0;
   int bad   = 0;

   imm_ext_arbiter #(.TAGW(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_imm0  (req_imm0),
      .req_imm1  (req_imm1),
      .req_ctrl0 (req_ctrl0),
      .req_ctrl1 (req_ctrl1),
      .req_lock  (req_lock),
      .req_tag0  (req_tag0),
      .req_tag1  (req_tag1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_imm   (out_imm),
      .out_port  (out_port),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      req_lock  = '0;
      out_ready = 1'b1;
      tick();
      tick();
      #2 rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 2'b11;
      req_imm0 = '0; req_imm1 = '0;
      req_ctrl0 = '0; req_ctrl1 = '0;
      req_lock = '0; req_tag0 = 4'h5; req_tag1 = 4'hA;
      out_ready = 1'b1;
      tick();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      total++;
      if (out_imm !== 64'h0) begin bad++; $display("FAIL reset_imm got=%h exp=0", out_imm); end
      total++;
      if (out_port !== 1'b0 || out_tag !== 4'h0) begin bad++; $display("FAIL reset_port_tag got=%b/%h exp=0/0", out_port, out_tag); end
      total++;
      if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
      req_valid = '0;
      #2 rst = 1'b0;
      tick();
   endtask

   task automatic test_formats();
      // port 0, FMT_I, I[21:10]=0xFFF
      req_valid = 2'b01; req_ctrl0 = 3'b000; req_imm0 = 26'h3FFC00; req_tag0 = 4'h5;
      #1;
      total++;
      if (req_ready !== 2'b01) begin bad++; $display("FAIL fmt_i_ready got=%b exp=01", req_ready); end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_imm !== 64'h0000000000000FFF || out_port !== 1'b0 || out_tag !== 4'h5) begin
         bad++; $display("FAIL fmt_i got=%b/%h/%b/%h exp=1/0000000000000fff/0/5", out_valid, out_imm, out_port, out_tag);
      end
      // port 0, FMT_D, I[20:12]=0x100
      req_ctrl0 = 3'b001; req_imm0 = 26'h100000;
      tick();
      total++;
      if (out_imm !== 64'hFFFFFFFFFFFFFF00) begin bad++; $display("FAIL fmt_d got=%h exp=ffffffffffffff00", out_imm); end
      // port 1, FMT_B, all ones
      req_valid = 2'b10; req_ctrl1 = 3'b010; req_imm1 = 26'h3FFFFFF; req_tag1 = 4'hA;
      tick();
      total++;
      if (out_imm !== 64'hFFFFFFFFFFFFFFFC || out_port !== 1'b1 || out_tag !== 4'hA) begin
         bad++; $display("FAIL fmt_b got=%h/%b/%h exp=fffffffffffffffc/1/a", out_imm, out_port, out_tag);
      end
      // port 1, FMT_CB, I[23:5]=0x40000
      req_ctrl1 = 3'b011; req_imm1 = 26'h0800000;
      tick();
      total++;
      if (out_imm !== 64'hFFFFFFFFFFF00000) begin bad++; $display("FAIL fmt_cb got=%h exp=fffffffffff00000", out_imm); end
      // drain: out_valid clears, payload holds
      req_valid = '0;
      tick();
      total++;
      if (out_valid !== 1'b0 || out_imm !== 64'hFFFFFFFFFFF00000 || out_port !== 1'b1) begin
         bad++; $display("FAIL drain_hold got=%b/%h/%b exp=0/fffffffffff00000/1", out_valid, out_imm, out_port);
      end
   endtask

   task automatic test_alternate();
      logic [1:0] exp_rdy [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
      do_reset();
      req_valid = 2'b11;
      req_ctrl0 = 3'b100; req_imm0 = 26'h0000020;  // MOV0 of 1
      req_ctrl1 = 3'b100; req_imm1 = 26'h0000040;  // MOV0 of 2
      req_tag0 = 4'h3; req_tag1 = 4'hC;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++;
         if (req_ready !== exp_rdy[i]) begin bad++; $display("FAIL alt_grant%0d got=%b exp=%b", i, req_ready, exp_rdy[i]); end
         tick();
         total++;
         if (out_valid !== 1'b1 || out_port !== exp_rdy[i][1] ||
             out_imm !== (exp_rdy[i][1] ? 64'd2 : 64'd1) || out_tag !== (exp_rdy[i][1] ? 4'hC : 4'h3)) begin
            bad++; $display("FAIL alt_out%0d got=%b/%b/%h/%h exp port=%b", i, out_valid, out_port, out_imm, out_tag, exp_rdy[i][1]);
         end
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_lock_burst();
      logic [63:0] exp_imm [4] = '{64'h1234000000000000, 64'h0000123400000000,
                                   64'h0000000012340000, 64'h0000000000001234};
      do_reset();
      req_valid = 2'b11;
      req_imm0 = 26'h0024680;  // I[20:5]=0x1234
      req_ctrl1 = 3'b000; req_imm1 = 26'h0000400; req_tag1 = 4'h9;
      for (int k = 0; k < 4; k++) begin
         req_ctrl0 = 3'(7 - k);
         req_lock  = {1'b0, (k < 3)};
         req_valid = 2'b11;
         #1;
         total++;
         if (req_ready !== 2'b01) begin bad++; $display("FAIL lock_grant%0d got=%b exp=01", k, req_ready); end
         tick();
         total++;
         if (out_valid !== 1'b1 || out_imm !== exp_imm[k] || out_port !== 1'b0) begin
            bad++; $display("FAIL lock_beat%0d got=%b/%h/%b exp=1/%h/0", k, out_valid, out_imm, out_port, exp_imm[k]);
         end
         if (k == 1) begin
            // port 0 idle while locked: port 1 must still be stalled
            req_valid = 2'b10;
            #1;
            total++;
            if (req_ready !== 2'b00) begin bad++; $display("FAIL lock_stall got=%b exp=00", req_ready); end
            tick();
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL lock_stall_valid got=%b exp=0", out_valid); end
         end
      end
      // lock released: port 1 wins (last_grant=0) even with port 0 valid
      req_lock = '0;
      #1;
      total++;
      if (req_ready !== 2'b10) begin bad++; $display("FAIL lock_release got=%b exp=10", req_ready); end
      tick();
      total++;
      if (out_port !== 1'b1 || out_imm !== 64'h1 || out_tag !== 4'h9) begin
         bad++; $display("FAIL lock_release_out got=%b/%h/%h exp=1/1/9", out_port, out_imm, out_tag);
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      req_valid = 2'b11;
      req_ctrl0 = 3'b000; req_imm0 = 26'h0001400;  // I[21:10]=5
      req_ctrl1 = 3'b000; req_imm1 = 26'h0001C00;  // I[21:10]=7
      req_tag0 = 4'h1; req_tag1 = 4'h2;
      tick();  // port 0 accepted
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         total++;
         if (req_ready !== 2'b00) begin bad++; $display("FAIL bp_ready%0d got=%b exp=00", c, req_ready); end
         tick();
         total++;
         if (out_valid !== 1'b1 || out_imm !== 64'd5 || out_port !== 1'b0 || out_tag !== 4'h1) begin
            bad++; $display("FAIL bp_hold%0d got=%b/%h/%b/%h exp=1/5/0/1", c, out_valid, out_imm, out_port, out_tag);
         end
      end
      out_ready = 1'b1;
      #1;
      total++;
      if (req_ready !== 2'b10) begin bad++; $display("FAIL bp_release got=%b exp=10", req_ready); end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_imm !== 64'd7 || out_port !== 1'b1 || out_tag !== 4'h2) begin
         bad++; $display("FAIL bp_refill got=%b/%h/%b/%h exp=1/7/1/2", out_valid, out_imm, out_port, out_tag);
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_reset_midburst();
      do_reset();
      req_valid = 2'b01; req_lock = 2'b01;
      req_ctrl0 = 3'b111; req_imm0 = 26'h0024680;
      tick();  // LOCK0, out_valid=1
      out_ready = 1'b0;
      req_valid = 2'b10; req_lock = '0;
      req_ctrl1 = 3'b100; req_imm1 = 26'h0000060; req_tag1 = 4'h7;  // MOV0 of 3
      #1;
      total++;
      if (req_ready !== 2'b00) begin bad++; $display("FAIL mid_pre_ready got=%b exp=00", req_ready); end
      #1 rst = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_imm !== 64'h0) begin
         bad++; $display("FAIL mid_reset got=%b/%h exp=0/0", out_valid, out_imm);
      end
      out_ready = 1'b1;
      tick();
      #2 rst = 1'b0;
      #1;
      total++;
      if (req_ready !== 2'b10) begin bad++; $display("FAIL mid_unlock got=%b exp=10", req_ready); end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_port !== 1'b1 || out_imm !== 64'd3 || out_tag !== 4'h7) begin
         bad++; $display("FAIL mid_after got=%b/%b/%h/%h exp=1/1/3/7", out_valid, out_port, out_imm, out_tag);
      end
      req_valid = '0;
      tick();
   endtask

   initial begin
      test_reset();
      test_formats();
      test_alternate();
      test_lock_burst();
      test_backpressure();
      test_reset_midburst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
